mc_control_unit: RTL
====================

MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 Parameter OPW, default 6: opcode width; legal values 4..8.
REQ-002 Parameter TIMEOUT, default 16: memory wait-state limit in cycles; legal range 2..255.
REQ-003 The port list SHALL be exactly as below. Each line gives name, direction, width and meaning; clock and reset come first.
REQ-004 clk  in  1  clock; the reset is rst, synchronous, active-high.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 opcode  in  OPW  instruction opcode from IR; sampled only in DECODE, MEM_ADDR and EXC-entry decisions.
REQ-007 mem_ready  in  1  memory handshake; high = access completes this cycle.
REQ-008 RegDst, RegWrite, MemRead, MemWrite, MemtoReg, IorD, IRWrite, ALUSrcA, PCWrite, PCWriteCond, BranchNe, EPCWrite  out  1 each  datapath controls.
REQ-009 ALUSrcB, ALUOp, PCSource  out  2 each  datapath selects; PCSource 3 = exception vector.
REQ-010 cause  out  2  last exception cause: 0 none, 1 illegal opcode, 2 bus timeout.
REQ-011 state  out  4  current state encoding, for debug.

Function
REQ-012 Every output SHALL be a pure function of the current state, mem_ready and opcode (Moore/Mealy-gated), with every output driven in every state and no latches; unlisted controls are 0.
REQ-013 Opcode map: 0-4 R-type; 5-9 I-type; 10 LW; 11 SW; 12 BEQ; 13 J; 14 BNE; all others are illegal.
REQ-014 States and encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EX 6, R_WB 7, I_EX 8, I_WB 9, BRANCH 10, JUMP 11, EXC 12; codes 13-15 go to FETCH.
REQ-015 FETCH: MemRead=1, ALUSrcB=1, ALUOp=0, PCSource=0, IRWrite=PCWrite=mem_ready. Go to DECODE when mem_ready=1; otherwise stay.
REQ-016 DECODE: ALUSrcB=3, ALUOp=0. Next state per opcode: R->R_EX, I->I_EX, LW/SW->MEM_ADDR, BEQ/BNE->BRANCH, J->JUMP, illegal->EXC with cause:=1.
REQ-017 R_EX: ALUSrcA=1, ALUSrcB=0, ALUOp=2; next R_WB. R_WB: RegDst=1, RegWrite=1, MemtoReg=0; next FETCH.
REQ-018 I_EX: ALUSrcA=1, ALUSrcB=2, ALUOp=2; next I_WB. I_WB: RegDst=0, RegWrite=1, MemtoReg=0; next FETCH.
REQ-019 MEM_ADDR: ALUSrcA=1, ALUSrcB=2, ALUOp=0; opcode 10 -> MEM_RD, 11 -> MEM_WR.
REQ-020 MEM_RD: MemRead=1, IorD=1; go to MEM_WB on mem_ready, else stay. MEM_WB: RegDst=0, RegWrite=1, MemtoReg=1; next FETCH.
REQ-021 MEM_WR: MemWrite=1, IorD=1; go to FETCH on mem_ready, else stay.
REQ-022 BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=1, PCWriteCond=1, PCSource=1, BranchNe=(opcode==14); next FETCH.
REQ-023 JUMP: PCWrite=1, PCSource=2; next FETCH.
REQ-024 EXC: EPCWrite=1, PCWrite=1, PCSource=3, lasting exactly one cycle; next FETCH.
REQ-025 Wait counter (8-bit): cleared on every state change; increments each cycle in FETCH, MEM_RD or MEM_WR while mem_ready=0.
REQ-026 When the counter equals TIMEOUT-1 and mem_ready=0 in a wait state, next state SHALL be EXC with cause:=2; MemWrite/IRWrite/PCWrite stay 0 that cycle.
REQ-027 If mem_ready=1 in the same cycle the counter reaches TIMEOUT-1, the access completes normally and no exception is raised.
REQ-028 cause SHALL hold its value until the next exception or reset.

Reset
REQ-029 rst SHALL force state=FETCH, counter=0 and cause=0 on the next clk edge, overriding any transition, including mid-wait and during EXC.
REQ-030 While rst is high, outputs SHALL reflect FETCH; no other output has separate reset logic.

Structure
REQ-031 A shared package mc_pkg SHALL hold the state encodings, the opcode constants, the ALUOp/ALUSrcB/PCSource codes and the cause codes.
REQ-032 One sub-module, mc_wait_timer (counter plus timeout compare, parameter TIMEOUT), SHALL be instantiated; the FSM and decode stay in mc_control_unit.

Verification
REQ-033 R-type: opcode 3, mem_ready=1 -> states 0,1,6,7,0; RegWrite=1 only in R_WB; 4 cycles per instruction.
REQ-034 LW with 2 wait cycles in MEM_RD: opcode 10 -> states 0,1,2,3,3,3,4,0; MemtoReg=1 in state 4.
REQ-035 BNE: opcode 14 -> BRANCH with BranchNe=1, PCWriteCond=1; BEQ (12) gives BranchNe=0.
REQ-036 Illegal opcode: opcode 20 -> DECODE then EXC, EPCWrite=1 for 1 cycle, cause=1, then FETCH.
REQ-037 Timeout: TIMEOUT=4, mem_ready=0 in MEM_WR -> 4 cycles in MEM_WR, then EXC, cause=2; a second run with mem_ready=1 on the 4th cycle -> FETCH, no exception.
REQ-038 Reset mid-MEM_RD wait -> state=0, cause=0 on the next edge; normal fetch resumes.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle control unit: states, opcodes, datapath selects, causes.
// Pure definitions; no timing or flow control involved.
package mc_pkg;

   typedef enum logic [3:0] {
      ST_FETCH    = 4'd0,
      ST_DECODE   = 4'd1,
      ST_MEM_ADDR = 4'd2,
      ST_MEM_RD   = 4'd3,
      ST_MEM_WB   = 4'd4,
      ST_MEM_WR   = 4'd5,
      ST_R_EX     = 4'd6,
      ST_R_WB     = 4'd7,
      ST_I_EX     = 4'd8,
      ST_I_WB     = 4'd9,
      ST_BRANCH   = 4'd10,
      ST_JUMP     = 4'd11,
      ST_EXC      = 4'd12
   } state_t;

   localparam logic [7:0] OP_R_HI = 8'd4;
   localparam logic [7:0] OP_I_LO = 8'd5;
   localparam logic [7:0] OP_I_HI = 8'd9;
   localparam logic [7:0] OP_LW   = 8'd10;
   localparam logic [7:0] OP_SW   = 8'd11;
   localparam logic [7:0] OP_BEQ  = 8'd12;
   localparam logic [7:0] OP_J    = 8'd13;
   localparam logic [7:0] OP_BNE  = 8'd14;

   localparam logic [1:0] ALUOP_ADD  = 2'd0;
   localparam logic [1:0] ALUOP_SUB  = 2'd1;
   localparam logic [1:0] ALUOP_FUNC = 2'd2;

   localparam logic [1:0] SRCB_REG  = 2'd0;
   localparam logic [1:0] SRCB_FOUR = 2'd1;
   localparam logic [1:0] SRCB_IMM  = 2'd2;
   localparam logic [1:0] SRCB_BOFF = 2'd3;

   localparam logic [1:0] PCSRC_ALU    = 2'd0;
   localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
   localparam logic [1:0] PCSRC_JUMP   = 2'd2;
   localparam logic [1:0] PCSRC_EXC    = 2'd3;

   localparam logic [1:0] CAUSE_NONE    = 2'd0;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

   typedef enum logic [2:0] {
      OPC_R, OPC_I, OPC_MEM, OPC_BR, OPC_J, OPC_ILL
   } op_class_t;

   typedef struct packed {
      logic       reg_dst;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       i_or_d;
      logic       ir_write;
      logic       alu_src_a;
      logic       pc_write;
      logic       pc_write_cond;
      logic       branch_ne;
      logic       epc_write;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
   } ctrl_t;

   function automatic op_class_t classify(input logic [7:0] op);
      if (op <= OP_R_HI)                     return OPC_R;
      if (op >= OP_I_LO && op <= OP_I_HI)    return OPC_I;
      if (op == OP_LW || op == OP_SW)        return OPC_MEM;
      if (op == OP_BEQ || op == OP_BNE)      return OPC_BR;
      if (op == OP_J)                        return OPC_J;
      return OPC_ILL;
   endfunction

endpackage

// File: rtl/mc_control_unit_if.sv
// Controller-to-datapath bundle: IR opcode and memory handshake in, control strobes and selects out.
// Wiring only; master is the controller, slave is the datapath side.
interface mc_control_unit_if #(parameter int OPW = 6);

   logic [OPW-1:0] opcode;
   logic           mem_ready;
   logic           RegDst, RegWrite, MemRead, MemWrite, MemtoReg, IorD;
   logic           IRWrite, ALUSrcA, PCWrite, PCWriteCond, BranchNe, EPCWrite;
   logic [1:0]     ALUSrcB, ALUOp, PCSource;
   logic [1:0]     cause;
   logic [3:0]     state;

   modport master (
      input  opcode, mem_ready,
      output RegDst, RegWrite, MemRead, MemWrite, MemtoReg, IorD,
      output IRWrite, ALUSrcA, PCWrite, PCWriteCond, BranchNe, EPCWrite,
      output ALUSrcB, ALUOp, PCSource, cause, state
   );

   modport slave (
      output opcode, mem_ready,
      input  RegDst, RegWrite, MemRead, MemWrite, MemtoReg, IorD,
      input  IRWrite, ALUSrcA, PCWrite, PCWriteCond, BranchNe, EPCWrite,
      input  ALUSrcB, ALUOp, PCSource, cause, state
   );

endinterface

// File: rtl/mc_wait_timer.sv
// Memory wait-state counter; o_expired is a same-cycle compare against TIMEOUT-1.
// Clear has priority over increment; no flow control of its own.
module mc_wait_timer #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_inc,
   output logic o_expired
);

   logic [7:0] r_count;

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_count <= '0;
      end else if (i_inc) begin
         r_count <= r_count + 8'd1;
      end
   end

   assign o_expired = (r_count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle CPU control FSM: outputs decode combinationally from state, mem_ready and opcode.
// Wait states stall on mem_ready=0 and trap to EXC once the wait timer expires.
module mc_control_unit
   import mc_pkg::*;
#(
   parameter int OPW     = 6,
   parameter int TIMEOUT = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [OPW-1:0] opcode,
   input  logic           mem_ready,
   output logic           RegDst,
   output logic           RegWrite,
   output logic           MemRead,
   output logic           MemWrite,
   output logic           MemtoReg,
   output logic           IorD,
   output logic           IRWrite,
   output logic           ALUSrcA,
   output logic           PCWrite,
   output logic           PCWriteCond,
   output logic           BranchNe,
   output logic           EPCWrite,
   output logic [1:0]     ALUSrcB,
   output logic [1:0]     ALUOp,
   output logic [1:0]     PCSource,
   output logic [1:0]     cause,
   output logic [3:0]     state
);

   state_t     r_state;
   state_t     w_cur;
   state_t     w_next;
   logic [1:0] r_cause;
   logic [1:0] w_cause_next;
   logic [7:0] w_op8;
   logic       w_wait_st;
   logic       w_expired;
   logic       w_timeout;
   ctrl_t      w_ctl;

   // Reset forces the decode to FETCH immediately, not just after the edge.
   assign w_cur = rst ? ST_FETCH : r_state;

   always_comb begin
      w_op8          = '0;
      w_op8[OPW-1:0] = opcode;
   end

   assign w_wait_st = (w_cur == ST_FETCH) || (w_cur == ST_MEM_RD) || (w_cur == ST_MEM_WR);
   assign w_timeout = w_wait_st && !mem_ready && w_expired;

   mc_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
      .clk       (clk),
      .rst       (rst),
      .i_clr     (w_next != r_state),
      .i_inc     (w_wait_st && !mem_ready),
      .o_expired (w_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_FETCH;
         r_cause <= CAUSE_NONE;
      end else begin
         r_state <= w_next;
         r_cause <= w_cause_next;
      end
   end

   always_comb begin
      w_next       = w_cur;
      w_cause_next = r_cause;
      w_ctl        = '0;
      case (w_cur)
         ST_FETCH: begin
            w_ctl.mem_read  = 1'b1;
            w_ctl.alu_src_b = SRCB_FOUR;
            w_ctl.alu_op    = ALUOP_ADD;
            w_ctl.pc_source = PCSRC_ALU;
            w_ctl.ir_write  = mem_ready;
            w_ctl.pc_write  = mem_ready;
            if (w_timeout) begin
               w_next       = ST_EXC;
               w_cause_next = CAUSE_TIMEOUT;
            end else if (mem_ready) begin
               w_next = ST_DECODE;
            end
         end
         ST_DECODE: begin
            w_ctl.alu_src_b = SRCB_BOFF;
            w_ctl.alu_op    = ALUOP_ADD;
            case (classify(w_op8))
               OPC_R:   w_next = ST_R_EX;
               OPC_I:   w_next = ST_I_EX;
               OPC_MEM: w_next = ST_MEM_ADDR;
               OPC_BR:  w_next = ST_BRANCH;
               OPC_J:   w_next = ST_JUMP;
               default: begin
                  w_next       = ST_EXC;
                  w_cause_next = CAUSE_ILLEGAL;
               end
            endcase
         end
         ST_MEM_ADDR: begin
            w_ctl.alu_src_a = 1'b1;
            w_ctl.alu_src_b = SRCB_IMM;
            w_ctl.alu_op    = ALUOP_ADD;
            // Opcode changing under us between DECODE and here is treated as illegal.
            if (w_op8 == OP_LW) begin
               w_next = ST_MEM_RD;
            end else if (w_op8 == OP_SW) begin
               w_next = ST_MEM_WR;
            end else begin
               w_next       = ST_EXC;
               w_cause_next = CAUSE_ILLEGAL;
            end
         end
         ST_MEM_RD: begin
            w_ctl.mem_read = 1'b1;
            w_ctl.i_or_d   = 1'b1;
            if (w_timeout) begin
               w_next       = ST_EXC;
               w_cause_next = CAUSE_TIMEOUT;
            end else if (mem_ready) begin
               w_next = ST_MEM_WB;
            end
         end
         ST_MEM_WB: begin
            w_ctl.reg_write  = 1'b1;
            w_ctl.mem_to_reg = 1'b1;
            w_next           = ST_FETCH;
         end
         ST_MEM_WR: begin
            w_ctl.mem_write = !w_timeout;
            w_ctl.i_or_d    = 1'b1;
            if (w_timeout) begin
               w_next       = ST_EXC;
               w_cause_next = CAUSE_TIMEOUT;
            end else if (mem_ready) begin
               w_next = ST_FETCH;
            end
         end
         ST_R_EX: begin
            w_ctl.alu_src_a = 1'b1;
            w_ctl.alu_src_b = SRCB_REG;
            w_ctl.alu_op    = ALUOP_FUNC;
            w_next          = ST_R_WB;
         end
         ST_R_WB: begin
            w_ctl.reg_dst   = 1'b1;
            w_ctl.reg_write = 1'b1;
            w_next          = ST_FETCH;
         end
         ST_I_EX: begin
            w_ctl.alu_src_a = 1'b1;
            w_ctl.alu_src_b = SRCB_IMM;
            w_ctl.alu_op    = ALUOP_FUNC;
            w_next          = ST_I_WB;
         end
         ST_I_WB: begin
            w_ctl.reg_write = 1'b1;
            w_next          = ST_FETCH;
         end
         ST_BRANCH: begin
            w_ctl.alu_src_a     = 1'b1;
            w_ctl.alu_src_b     = SRCB_REG;
            w_ctl.alu_op        = ALUOP_SUB;
            w_ctl.pc_write_cond = 1'b1;
            w_ctl.pc_source     = PCSRC_ALUOUT;
            w_ctl.branch_ne     = (w_op8 == OP_BNE);
            w_next              = ST_FETCH;
         end
         ST_JUMP: begin
            w_ctl.pc_write  = 1'b1;
            w_ctl.pc_source = PCSRC_JUMP;
            w_next          = ST_FETCH;
         end
         ST_EXC: begin
            w_ctl.epc_write = 1'b1;
            w_ctl.pc_write  = 1'b1;
            w_ctl.pc_source = PCSRC_EXC;
            w_next          = ST_FETCH;
         end
         default: w_next = ST_FETCH;
      endcase
   end

   assign RegDst      = w_ctl.reg_dst;
   assign RegWrite    = w_ctl.reg_write;
   assign MemRead     = w_ctl.mem_read;
   assign MemWrite    = w_ctl.mem_write;
   assign MemtoReg    = w_ctl.mem_to_reg;
   assign IorD        = w_ctl.i_or_d;
   assign IRWrite     = w_ctl.ir_write;
   assign ALUSrcA     = w_ctl.alu_src_a;
   assign PCWrite     = w_ctl.pc_write;
   assign PCWriteCond = w_ctl.pc_write_cond;
   assign BranchNe    = w_ctl.branch_ne;
   assign EPCWrite    = w_ctl.epc_write;
   assign ALUSrcB     = w_ctl.alu_src_b;
   assign ALUOp       = w_ctl.alu_op;
   assign PCSource    = w_ctl.pc_source;
   assign cause       = r_cause;
   assign state       = w_cur;

endmodule
